// File: rtl/icu_pkg.sv
// Shared definitions for the instruction-cache fill sequencer.
package icu_pkg;

  localparam int LINE_WORDS = 4;

  // Half-row write strobes of the 64-bit data RAM.
  localparam logic [1:0] WE_UPPER = 2'b10;
  localparam logic [1:0] WE_LOWER = 2'b01;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    FILL,
    DONE,
    ERR
  } state_t;

endpackage

// File: rtl/icu_fill_ctl.sv
// I-cache line fill sequencer: requests a line from the BIU and writes its
// four words into the 64-bit-row data RAM through the 32-bit half-row port.
module icu_fill_ctl
  import icu_pkg::*;
#(
  parameter int ADR_MSB    = 8,
  parameter int LINE_WORDS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 miss_req,
  input  logic [ADR_MSB-4:0]   miss_adr,
  output logic                 miss_ack,
  output logic                 busy,
  output logic                 biu_req,
  output logic [ADR_MSB:0]     biu_adr,
  input  logic                 biu_gnt,
  input  logic                 biu_valid,
  input  logic [31:0]          biu_data,
  input  logic                 biu_err,
  output logic [ADR_MSB-3:0]   ram_adr,
  output logic [31:0]          ram_di,
  output logic [1:0]           ram_we,
  output logic                 ram_enable,
  output logic                 fill_done,
  output logic                 fill_err
);

  localparam logic [1:0] LAST_WORD = 2'(LINE_WORDS - 1);

  state_t               state_q, state_d;
  logic [ADR_MSB-4:0]   line_q, line_d;
  logic [1:0]           wcnt_q, wcnt_d;

  logic                 miss_ack_d, busy_d, biu_req_d;
  logic [ADR_MSB:0]     biu_adr_d;
  logic [ADR_MSB-3:0]   ram_adr_d;
  logic [31:0]          ram_di_d;
  logic [1:0]           ram_we_d;
  logic                 ram_enable_d, fill_done_d, fill_err_d;

  // Every output is computed here one cycle ahead and registered below.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    state_d      = state_q;
    line_d       = line_q;
    wcnt_d       = wcnt_q;
    miss_ack_d   = 1'b0;
    biu_req_d    = 1'b0;
    biu_adr_d    = '0;
    ram_adr_d    = '0;
    ram_di_d     = '0;
    ram_we_d     = '0;
    ram_enable_d = 1'b0;
    fill_done_d  = 1'b0;
    fill_err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (miss_req) begin
          state_d    = REQ;
          line_d     = miss_adr;
          miss_ack_d = 1'b1;
          biu_req_d  = 1'b1;
          biu_adr_d  = {miss_adr, 4'b0000};
        end
      end
      REQ: begin
        if (biu_gnt) begin
          state_d = FILL;
          wcnt_d  = '0;
        end else begin
          biu_req_d = 1'b1;
          biu_adr_d = {line_q, 4'b0000};
        end
      end
      FILL: begin
        if (biu_valid && biu_err) begin
          state_d    = ERR;
          fill_err_d = 1'b1;
        end else if (biu_valid) begin
          // Even words land in the upper half of a row, odd words in the lower.
          ram_enable_d = 1'b1;
          ram_di_d     = biu_data;
          ram_adr_d    = {line_q, wcnt_q[1]};
          ram_we_d     = wcnt_q[0] ? WE_LOWER : WE_UPPER;
          wcnt_d       = wcnt_q + 2'd1;
          if (wcnt_q == LAST_WORD) begin
            state_d     = DONE;
            fill_done_d = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      line_q     <= '0;
      wcnt_q     <= '0;
      miss_ack   <= 1'b0;
      busy       <= 1'b0;
      biu_req    <= 1'b0;
      biu_adr    <= '0;
      ram_adr    <= '0;
      ram_di     <= '0;
      ram_we     <= '0;
      ram_enable <= 1'b0;
      fill_done  <= 1'b0;
      fill_err   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      line_q     <= line_d;
      wcnt_q     <= wcnt_d;
      miss_ack   <= miss_ack_d;
      busy       <= busy_d;
      biu_req    <= biu_req_d;
      biu_adr    <= biu_adr_d;
      ram_adr    <= ram_adr_d;
      ram_di     <= ram_di_d;
      ram_we     <= ram_we_d;
      ram_enable <= ram_enable_d;
      fill_done  <= fill_done_d;
      fill_err   <= fill_err_d;
    end
  end

endmodule

// File: tb/tb_icu_fill_ctl.sv
// Scoreboard bench for icu_fill_ctl: expected RAM writes are queued when BIU
// words are driven and compared, including their cycle, when the DUT writes.
module tb_icu_fill_ctl;

  localparam int ADR_MSB = 8;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 miss_req = 1'b0;
  logic [ADR_MSB-4:0]   miss_adr = '0;
  logic                 miss_ack;
  logic                 busy;
  logic                 biu_req;
  logic [ADR_MSB:0]     biu_adr;
  logic                 biu_gnt = 1'b0;
  logic                 biu_valid = 1'b0;
  logic [31:0]          biu_data = 32'hDEADBEEF;
  logic                 biu_err = 1'b0;
  logic [ADR_MSB-3:0]   ram_adr;
  logic [31:0]          ram_di;
  logic [1:0]           ram_we;
  logic                 ram_enable;
  logic                 fill_done;
  logic                 fill_err;

  icu_fill_ctl #(.ADR_MSB(ADR_MSB), .LINE_WORDS(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .miss_req   (miss_req),
    .miss_adr   (miss_adr),
    .miss_ack   (miss_ack),
    .busy       (busy),
    .biu_req    (biu_req),
    .biu_adr    (biu_adr),
    .biu_gnt    (biu_gnt),
    .biu_valid  (biu_valid),
    .biu_data   (biu_data),
    .biu_err    (biu_err),
    .ram_adr    (ram_adr),
    .ram_di     (ram_di),
    .ram_we     (ram_we),
    .ram_enable (ram_enable),
    .fill_done  (fill_done),
    .fill_err   (fill_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  adr;
    logic [1:0]  we;
    logic [31:0] di;
    logic [31:0] cyc;
  } wr_t;

  wr_t         sb[$];
  logic [31:0] cyc = '0;
  int          checks = 0;
  int          errors = 0;
  int          mon_done = 0, mon_err = 0, mon_ack = 0;
  int          exp_done = 0, exp_err = 0, exp_ack = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pulse counters plus scoreboard comparison of every RAM write.
  always @(negedge clk) begin
    wr_t e;
    if (fill_done) mon_done++;
    if (fill_err)  mon_err++;
    if (miss_ack)  mon_ack++;
    if (ram_enable) begin
      if (sb.size() == 0) begin
        check("wr_unexpected", {ram_adr, ram_we, ram_di}, 0);
      end else begin
        e = sb.pop_front();
        check("wr_adr", ram_adr, e.adr);
        check("wr_we",  ram_we,  e.we);
        check("wr_di",  ram_di,  e.di);
        check("wr_cyc", cyc,     e.cyc);
      end
    end else if (ram_we != 2'b00) begin
      check("we_without_enable", ram_we, 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"},
          {miss_ack, busy, biu_req, biu_adr, ram_adr, ram_di, ram_we, ram_enable, fill_done, fill_err},
          0);
  endtask

  task automatic request(input logic [4:0] adr, input bit hold);
    miss_req = 1'b1;
    miss_adr = adr;
    tick();
    exp_ack++;
    check("ack",     miss_ack, 1);
    check("req",     biu_req,  1);
    check("biu_adr", biu_adr,  {adr, 4'b0000});
    check("busy",    busy,     1);
    if (!hold) miss_req = 1'b0;
  endtask

  task automatic grant(input int delay);
    for (int i = 0; i < delay; i++) begin
      tick();
      check("ack_once", miss_ack, 0);
      check("req_hold", biu_req,  1);
    end
    biu_gnt = 1'b1;
    tick();
    biu_gnt = 1'b0;
    check("req_drop",  biu_req, 0);
    check("busy_fill", busy,    1);
  endtask

  function automatic logic [31:0] word_val(input logic [31:0] mult, input int w);
    return mult * 32'(w + 1);
  endfunction

  task automatic push_word(input logic [4:0] adr, input int w, input logic [31:0] d);
    wr_t e;
    e.adr = {adr, (w >= 2) ? 1'b1 : 1'b0};
    e.we  = (w % 2 == 0) ? 2'b10 : 2'b01;
    e.di  = d;
    e.cyc = cyc + 1;
    sb.push_back(e);
  endtask

  // Drives the four BIU words; err_at < 0 means a clean fill.
  task automatic words(input logic [4:0] adr, input logic [31:0] mult, input int gap, input int err_at);
    for (int w = 0; w < 4; w++) begin
      biu_valid = 1'b1;
      biu_data  = word_val(mult, w);
      biu_err   = (w == err_at);
      if (w != err_at) push_word(adr, w, biu_data);
      tick();
      biu_valid = 1'b0;
      biu_err   = 1'b0;
      biu_data  = 32'hDEADBEEF;
      if (w == err_at) begin
        exp_err++;
        check("err_pulse",      fill_err,   1);
        check("err_no_done",    fill_done,  0);
        check("err_no_write",   ram_enable, 0);
        tick();
        check("err_idle",       busy,       0);
        check("err_once",       fill_err,   0);
        return;
      end
      if (w == 3) begin
        exp_done++;
        check("done_pulse",     fill_done,  1);
        check("done_with_last", ram_enable, 1);
        tick();
        check("done_idle",      busy,       0);
        check("done_once",      fill_done,  0);
        return;
      end
      check("no_early_done", fill_done, 0);
      repeat (gap) tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;
    tick();

    // Basic fill: immediate grant, back-to-back words.
    request(5'h0A, 1'b0);
    grant(0);
    words(5'h0A, 32'h11111111, 0, -1);

    // Delayed grant and gapped data.
    tick();
    request(5'h05, 1'b0);
    grant(3);
    words(5'h05, 32'h0A0B0C0D, 1, -1);

    // Bus error on word 2.
    tick();
    request(5'h12, 1'b0);
    grant(0);
    words(5'h12, 32'h00C0FFEE, 0, 2);

    // Second miss held through a fill: accepted only in the first IDLE cycle.
    tick();
    request(5'h07, 1'b1);
    miss_adr = 5'h19;
    grant(1);
    words(5'h07, 32'h13579BDF, 0, -1);
    check("busy_miss_ignored", miss_ack, 0);
    tick();
    exp_ack++;
    check("late_ack",     miss_ack, 1);
    check("late_biu_adr", biu_adr,  {5'h19, 4'b0000});
    miss_req = 1'b0;
    grant(0);
    words(5'h19, 32'h2468ACE0, 0, -1);

    // Reset after word 1 is written, with word 2 already on the bus.
    tick();
    request(5'h03, 1'b0);
    grant(1);
    for (int w = 0; w < 2; w++) begin
      biu_valid = 1'b1;
      biu_data  = word_val(32'h31415926, w);
      push_word(5'h03, w, biu_data);
      tick();
    end
    biu_data = word_val(32'h31415926, 2);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    tick();
    biu_valid = 1'b0;
    biu_data  = 32'hDEADBEEF;
    tick();
    check_all_zero("held_reset");
    reset = 1'b0;
    tick();
    check("post_reset_idle", busy, 0);
    request(5'h1F, 1'b0);
    grant(0);
    words(5'h1F, 32'h0F1E2D3C, 0, -1);

    // Stray BIU traffic while idle.
    tick();
    biu_valid = 1'b1;
    biu_err   = 1'b1;
    biu_gnt   = 1'b1;
    repeat (3) begin
      tick();
      check("stray_quiet", {busy, biu_req, ram_enable, fill_done, fill_err, miss_ack}, 0);
    end
    biu_valid = 1'b0;
    biu_err   = 1'b0;
    biu_gnt   = 1'b0;
    tick();

    check("sb_drained", sb.size(), 0);
    check("done_count", mon_done, exp_done);
    check("err_count",  mon_err,  exp_err);
    check("ack_count",  mon_ack,  exp_ack);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
